// File: rtl/posit_pkg.sv
// posit_pkg: shared log2 helper, default posit geometry and the signed scale type
package posit_pkg;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  localparam int N_D = 32;
  localparam int ES_D = 2;
  localparam int BS_D = log2(N_D);
  localparam int SW_D = BS_D + ES_D + 2;
  typedef logic signed [SW_D-1:0] scale_t;
endpackage

// File: rtl/posit_regime_pack.sv
// posit_regime_pack: builds {0, regime, e, frac} with one arithmetic shift and splits it into kept bits, guard, round and sticky
module posit_regime_pack #(
  parameter int N  = 32,
  parameter int es = 2,
  parameter int SW = 9
) (
  input  logic signed [SW-1:0] k,
  input  logic [es-1:0]        e,
  input  logic [N-1:0]         frac,
  input  logic                 sticky,
  output logic [N-1:0]         mag,
  output logic                 g,
  output logic                 r,
  output logic                 st
);
  localparam int XW = 2 + es + 2 * N;
  logic          neg;
  logic [SW-1:0] sh;
  logic [XW-1:0] x, y;
  // the leading regime bit is replicated by the signed shift: k+1 ones for k>=0, -k zeros for k<0
  always_comb begin
    neg = k[SW-1];
    sh  = neg ? ~k : k;
    x   = {~neg, neg, e, frac, {N{1'b0}}};
    y   = $signed(x) >>> sh;
    mag = {1'b0, y[XW-1 -: N-1]};
    g   = y[XW-N];
    r   = y[XW-N-1];
    st  = |y[XW-N-2:0] | sticky;
  end
endmodule

// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: 3-stage posit encoder (decode scale, pack, round/negate); POSIT_ENC_RNE_EN enables round-to-nearest-even, otherwise truncates
module posit_encode_pipe
  import posit_pkg::*;
#(
  parameter int N  = N_D,
  parameter int es = ES_D,
  localparam int Bs = log2(N),
  localparam int SW = Bs + es + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_inf,
  input  logic [SW-1:0] in_scale,
  input  logic [N-1:0]  in_frac,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic          out_inf,
  output logic          out_zero
);
`ifdef POSIT_ENC_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  localparam logic signed [SW-1:0] SMAX = SW'((N - 2) << es);
  localparam logic signed [SW-1:0] SMIN = -SMAX;
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = N'(1);
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  logic                 ld1, ld2, ld3;
  logic                 v1, sign1, zero1, inf1, t1;
  logic signed [SW-1:0] k1, sc;
  logic [es-1:0]        e1;
  logic [N-1:0]         f1;
  logic                 v2, sign2, zero2, inf2, g2, r2, st2;
  logic [N-1:0]         mag2, mag_p;
  logic                 g_p, r_p, st_p, up;
  logic [N-1:0]         rnd, sat, res;
  assign ld3      = ~out_valid | out_ready;
  assign ld2      = ~v2 | ld3;
  assign ld1      = ~v1 | ld2;
  assign in_ready = ld1;
  // clamp the scale so the regime always fits inside the word
  always_comb sc = ($signed(in_scale) > SMAX) ? SMAX : ($signed(in_scale) < SMIN) ? SMIN : $signed(in_scale);
  // S1: split the clamped scale into regime count and exponent field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      zero1 <= 1'b0;
      inf1  <= 1'b0;
      t1    <= 1'b0;
      k1    <= '0;
      e1    <= '0;
      f1    <= '0;
    end else if (ld1) begin
      v1    <= in_valid;
      sign1 <= in_sign;
      zero1 <= in_zero;
      inf1  <= in_inf;
      t1    <= in_sticky;
      k1    <= sc >>> es;
      e1    <= sc[es-1:0];
      f1    <= in_frac;
    end
  end
  posit_regime_pack #(.N(N), .es(es), .SW(SW)) u_pack (
    .k      (k1),
    .e      (e1),
    .frac   (f1),
    .sticky (t1),
    .mag    (mag_p),
    .g      (g_p),
    .r      (r_p),
    .st     (st_p)
  );
  // S2: capture the packed magnitude and rounding bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      zero2 <= 1'b0;
      inf2  <= 1'b0;
      mag2  <= '0;
      g2    <= 1'b0;
      r2    <= 1'b0;
      st2   <= 1'b0;
    end else if (ld2) begin
      v2    <= v1;
      sign2 <= sign1;
      zero2 <= zero1;
      inf2  <= inf1;
      mag2  <= mag_p;
      g2    <= g_p;
      r2    <= r_p;
      st2   <= st_p;
    end
  end
  // round, keep nonzero finite results inside [minpos, maxpos], then apply sign and special values
  always_comb begin
    up  = RNE & g2 & (r2 | st2 | mag2[0]);
    rnd = mag2 + {{(N-1){1'b0}}, up};
    sat = rnd[N-1] ? MAXPOS : (rnd == '0) ? MINPOS : rnd;
    res = inf2 ? NAR : zero2 ? '0 : sign2 ? -sat : sat;
  end
  // S3: output register, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_inf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (ld3) begin
      out_valid <= v2;
      out_posit <= res;
      out_inf   <= inf2;
      out_zero  <= ~inf2 & zero2;
    end
  end
endmodule

// File: tb/tb_posit_encode_pipe.sv
// tb_posit_encode_pipe: directed table, stall/reset sequences and random beats against a bit-string posit model
module tb_posit_encode_pipe;
  import posit_pkg::*;
  localparam int N = 32;
  localparam int SW = SW_D;
  typedef struct {
    bit        s, z, i;
    int        sc;
    bit [31:0] f;
    bit        st;
    bit [31:0] p;
    bit        oi, oz;
  } vec_t;
  typedef struct {
    bit [33:0] x;
    int        c;
  } sb_t;
  logic          clk = 0, rst = 1;
  logic          in_valid = 0, in_ready, in_sign = 0, in_zero = 0, in_inf = 0, in_sticky = 0;
  logic [SW-1:0] in_scale = '0;
  logic [N-1:0]  in_frac = '0;
  logic          out_valid, out_ready = 1, out_inf, out_zero;
  logic [N-1:0]  out_posit;
  int checks = 0, errors = 0;
  int cyc = 0, acc = 0, ph = 0, mode = 0, fall = -1, acc0 = 0;
  bit lat_chk = 0;
  bit [33:0] cur_exp;
  sb_t exp_q[$];
  vec_t tv[12];
  posit_encode_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_inf    (in_inf),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit),
    .out_inf   (out_inf),
    .out_zero  (out_zero)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction
  function automatic bit [33:0] ref_enc(input bit s, z, i, input int sc_in, input bit [31:0] f, input bit st);
    bit q[$];
    int sc, k, e;
    bit [31:0] m;
    bit g, rest;
    if (i) return {2'b10, 32'h80000000};
    if (z) return {2'b01, 32'h0};
    sc = sc_in > 120 ? 120 : sc_in < -120 ? -120 : sc_in;
    e = ((sc % 4) + 4) % 4;
    k = (sc - e) / 4;
    q.push_back(1'b0);
    if (k >= 0) begin
      repeat (k + 1) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      repeat (-k) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    q.push_back(e[1]);
    q.push_back(e[0]);
    for (int b = 31; b >= 0; b--) q.push_back(f[b]);
    m = 0;
    for (int b = 0; b < 32; b++) m = {m[30:0], q[b]};
    g = q[32];
    rest = st;
    for (int b = 33; b < q.size(); b++) rest |= q[b];
`ifdef POSIT_ENC_RNE_EN
    if (g && (rest || m[0])) m = m + 1;
`else
    if (g && rest && 1'b0) m = m + 1;
`endif
    if (m[31]) m = 32'h7FFFFFFF;
    if (m == 0) m = 1;
    if (s) m = -m;
    return {2'b00, m};
  endfunction
  task automatic tick();
    sb_t e;
    if (mode == 1) out_ready = !(ph >= 2 && ph <= 7);
    else if (mode == 2) out_ready = ($urandom_range(0, 9) < 7);
    @(negedge clk);
    if (mode == 1 && in_valid && !in_ready && fall < 0) fall = acc - acc0;
    if (in_valid && in_ready) begin
      exp_q.push_back('{cur_exp, cyc});
      acc++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_out", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("posit", out_posit, e.x[31:0]);
        chk("inf", out_inf, e.x[33]);
        chk("zero", out_zero, e.x[32]);
        if (lat_chk) chk("latency", cyc - e.c, 3);
      end
    end
    cyc++;
    ph++;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit s, z, i, input int sc, input bit [31:0] f, input bit st, input bit [33:0] x);
    int a0, n;
    a0 = acc;
    n = 0;
    in_sign = s;
    in_zero = z;
    in_inf = i;
    in_scale = SW'(sc);
    in_frac = f;
    in_sticky = st;
    cur_exp = x;
    in_valid = 1;
    while (acc == a0 && n < 50) begin
      tick();
      n++;
    end
    if (acc == a0) chk("accept_timeout", in_ready, 1);
    in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) tick();
  endtask
  initial begin
    bit s, z, i, st;
    int sc;
    bit [31:0] f;
    tv[0]  = '{0, 0, 0, 0,    32'h0,  0, 32'h40000000, 0, 0};
    tv[1]  = '{1, 0, 0, 0,    32'h0,  0, 32'hC0000000, 0, 0};
    tv[2]  = '{0, 0, 0, 4,    32'h0,  0, 32'h60000000, 0, 0};
    tv[3]  = '{0, 0, 0, 200,  32'h0,  0, 32'h7FFFFFFF, 0, 0};
    tv[4]  = '{0, 0, 0, -200, 32'h0,  0, 32'h00000001, 0, 0};
    tv[5]  = '{0, 1, 0, 7,    32'h5,  1, 32'h00000000, 0, 1};
    tv[6]  = '{1, 1, 1, 3,    32'h9,  0, 32'h80000000, 1, 0};
    tv[7]  = '{0, 0, 0, 0,    32'h10, 0, 32'h40000000, 0, 0};
`ifdef POSIT_ENC_RNE_EN
    tv[8]  = '{0, 0, 0, 0,    32'h30, 0, 32'h40000002, 0, 0};
    tv[9]  = '{0, 0, 0, 0,    32'h10, 1, 32'h40000001, 0, 0};
`else
    tv[8]  = '{0, 0, 0, 0,    32'h30, 0, 32'h40000001, 0, 0};
    tv[9]  = '{0, 0, 0, 0,    32'h10, 1, 32'h40000000, 0, 0};
`endif
    tv[10] = '{1, 0, 0, 200,  32'hFFFFFFFF, 1, 32'h80000001, 0, 0};
    tv[11] = '{1, 0, 0, -200, 32'h0,  0, 32'hFFFFFFFF, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_posit", out_posit, 0);
    chk("rst_out_inf", out_inf, 0);
    chk("rst_out_zero", out_zero, 0);
    rst = 0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    lat_chk = 1;
    foreach (tv[n]) send(tv[n].s, tv[n].z, tv[n].i, tv[n].sc, tv[n].f, tv[n].st, {tv[n].oi, tv[n].oz, tv[n].p});
    drain();
    lat_chk = 0;
    mode = 1;
    ph = 0;
    fall = -1;
    acc0 = acc;
    for (int n = 0; n < 6; n++) begin
      sc = 4 * n - 8;
      send(0, 0, 0, sc, 32'h0, 0, ref_enc(0, 0, 0, sc, 32'h0, 0));
    end
    chk("stall_in_ready_fall", fall, 3);
    chk("stall_accepts", acc - acc0, 6);
    drain();
    mode = 0;
    out_ready = 0;
    send(0, 0, 0, 8, 32'h0, 0, ref_enc(0, 0, 0, 8, 32'h0, 0));
    send(1, 0, 0, 12, 32'h0, 0, ref_enc(1, 0, 0, 12, 32'h0, 0));
    tick();
    chk("inflight_out_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_posit", out_posit, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    chk("in_ready_post_rst", in_ready, 1);
    out_ready = 1;
    repeat (8) tick();
    mode = 2;
    for (int n = 0; n < 300; n++) begin
      s = 1'($urandom_range(0, 1));
      z = ($urandom_range(0, 19) == 0);
      i = ($urandom_range(0, 29) == 0);
      sc = $urandom_range(0, 1) ? int'($urandom_range(0, 64)) - 32 : int'($signed(SW'($urandom)));
      f = $urandom;
      st = 1'($urandom_range(0, 1));
      send(s, z, i, sc, f, st, ref_enc(s, z, i, sc, f, st));
      if ($urandom_range(0, 4) == 0) tick();
    end
    mode = 0;
    out_ready = 1;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
